datamem_sized: RTL and testbench

Parametrised, byte-addressed RV32 data memory with RISC-V load/store sizing, sign/zero extension, misalignment detection and a valid/ready request port with programmable read latency. It serves the LSU of the pipelined core as the data-side memory. It adds sized access, error reporting and multi-cycle timing for cache/latency experiments.

---
 rtl/datamem_sized_if.sv | 39 +++
 rtl/datamem_sized.sv | 147 ++++++++++++++
 tb/tb_datamem_sized.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_sized_if.sv
// Request/response bus between the LSU (master) and data memory (slave).
// req_*: valid/ready request; rsp_*: one-cycle response, no backpressure.
interface datamem_sized_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_funct3,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_funct3,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/datamem_sized.sv
// Byte-addressed RV32 data memory: B/H/W sized access, extension, error flag.
// Ports: clk, rst_n (async, active low), bus (slave side of datamem_sized_if).
module datamem_sized #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 1,
  parameter     INIT_FILE  = ""
) (
  input  logic           clk,
  input  logic           rst_n,
  datamem_sized_if.slave bus
);
  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [WORDS];

  logic                  acc;
  logic [ADDR_WIDTH-3:0] widx;
  logic [1:0]            off;
  logic [2:0]            f3;
  logic                  is_b;
  logic                  is_h;
  logic                  is_w;
  logic                  legal;
  logic                  mis;
  logic                  err;
  logic                  ld_ok;
  logic [31:0]           rd_word;
  logic [31:0]           lane;
  logic [31:0]           ld_data;
  logic [31:0]           wd_sh;
  logic [3:0]            be;

  logic        rv_q;
  logic [31:0] rd_q;
  logic        er_q;
  logic [31:0] p_rd;
  logic        p_er;

  logic unused_hi;

  assign unused_hi = ^bus.req_addr[DATA_WIDTH-1:ADDR_WIDTH];

  assign acc  = bus.req_valid & bus.req_ready;
  assign widx = bus.req_addr[ADDR_WIDTH-1:2];
  assign off  = bus.req_addr[1:0];
  assign f3   = bus.req_funct3;

  assign is_b  = f3[1:0] == 2'b00;
  assign is_h  = f3[1:0] == 2'b01;
  assign is_w  = f3 == 3'b010;
  // 100/101 exist only as unsigned loads
  assign legal = (~f3[2] & (f3[1:0] != 2'b11))
               | (~bus.req_we & f3[2] & ~f3[1]);
  assign mis   = (is_h & off[0]) | (is_w & (|off));
  assign err   = ~legal | mis;
  assign ld_ok = ~bus.req_we & ~err;

  assign rd_word = mem[widx];
  assign lane    = rd_word >> {off, 3'b000};
  assign wd_sh   = bus.req_wdata << {off, 3'b000};
  assign be      = (is_b ? 4'b0001 :
                    is_h ? 4'b0011 : 4'b1111) << off;

  always_comb begin
    ld_data = '0;
    unique case (1'b1)
      ld_ok && f3 == 3'b000:
        ld_data = {{24{lane[7]}}, lane[7:0]};
      ld_ok && f3 == 3'b001:
        ld_data = {{16{lane[15]}}, lane[15:0]};
      ld_ok && f3 == 3'b010:
        ld_data = rd_word;
      ld_ok && f3 == 3'b100:
        ld_data = {24'h0, lane[7:0]};
      ld_ok && f3 == 3'b101:
        ld_data = {16'h0, lane[15:0]};
      default:
        ld_data = '0;
    endcase
  end

  // Array has no reset; accepted stores survive a later reset.
  always_ff @(posedge clk) begin
    if (acc && bus.req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wd_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rv_q  <= 1'b0;
      rd_q  <= '0;
      er_q  <= 1'b0;
      p_rd  <= '0;
      p_er  <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (acc && LATENCY == 1) begin
            state <= RESP;
            rv_q  <= 1'b1;
            rd_q  <= ld_data;
            er_q  <= err;
          end else if (acc) begin
            state <= WAIT;
            cnt   <= CNT_INIT;
            p_rd  <= ld_data;
            p_er  <= err;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            rv_q  <= 1'b1;
            rd_q  <= p_rd;
            er_q  <= p_er;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state != WAIT) & rst_n;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rd_q;
  assign bus.rsp_err   = er_q;
endmodule

// File: tb/tb_datamem_sized.sv
// Bench for datamem_sized: LATENCY=1 and LATENCY=3 instances,
// directed + random sized accesses against a byte-array model.
module tb_datamem_sized;
  logic clk;
  logic rst_n;
  bit   sel;
  logic v;
  logic w;
  logic [2:0]  f;
  logic [31:0] a;
  logic [31:0] d;
  int checks;
  int fails;
  logic [7:0] mdl [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  datamem_sized_if #(.DATA_WIDTH(32)) b1 ();
  datamem_sized_if #(.DATA_WIDTH(32)) b3 ();

  assign b1.req_valid  = v & ~sel;
  assign b1.req_we     = w;
  assign b1.req_funct3 = f;
  assign b1.req_addr   = a;
  assign b1.req_wdata  = d;
  assign b3.req_valid  = v & sel;
  assign b3.req_we     = w;
  assign b3.req_funct3 = f;
  assign b3.req_addr   = a;
  assign b3.req_wdata  = d;

  wire        rdy   = sel ? b3.req_ready : b1.req_ready;
  wire        rvld  = sel ? b3.rsp_valid : b1.rsp_valid;
  wire [31:0] rdata = sel ? b3.rsp_rdata : b1.rsp_rdata;
  wire        rerr  = sel ? b3.rsp_err   : b1.rsp_err;

  datamem_sized #(
    .DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  datamem_sized #(
    .DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(3)
  ) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s sel=%0d got=%h exp=%h",
               tag, sel, got, exp);
    end
  endtask

  function automatic int key(input bit s,
                             input logic [16:0] ad);
    return int'({14'b0, s, ad});
  endfunction

  // Reference: bytes stored little-endian, per-instance.
  function automatic void model(input bit s,
                                input bit we_i,
                                input logic [2:0] f_i,
                                input logic [31:0] a_i,
                                input logic [31:0] d_i,
                                output logic [31:0] rd,
                                output logic er);
    int n;
    bit sg;
    logic [16:0] ad;
    logic [31:0] val;
    ad = a_i[16:0];
    rd = '0;
    er = 1'b0;
    val = '0;
    n = 0;
    sg = 1'b0;
    case (f_i)
      3'd0: begin n = 1; sg = 1'b1; end
      3'd1: begin n = 2; sg = 1'b1; end
      3'd2: n = 4;
      3'd4: n = we_i ? 0 : 1;
      3'd5: n = we_i ? 0 : 2;
      default: n = 0;
    endcase
    if (n == 0 || (ad % n) != 0) begin
      er = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (we_i) mdl[key(s, 17'(ad + i))] = d_i[8*i +: 8];
      else val[8*i +: 8] = mdl[key(s, 17'(ad + i))];
    end
    if (!we_i && sg && val[8*n-1])
      val = val | ~((32'h1 << (8*n)) - 1);
    if (!we_i) rd = val;
  endfunction

  task automatic xact(input bit w_i,
                      input logic [2:0] f_i,
                      input logic [31:0] a_i,
                      input logic [31:0] d_i);
    logic [31:0] erd;
    logic eer;
    int n;
    model(sel, w_i, f_i, a_i, d_i, erd, eer);
    w = w_i;
    f = f_i;
    a = a_i;
    d = d_i;
    v = 1'b1;
    n = 0;
    while (rdy !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready", rdy, 1);
    @(posedge clk); #1;
    v = 1'b0;
    n = 1;
    while (rvld !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, sel ? 3 : 1);
    chk("rdata", rdata, erd);
    chk("err", rerr, eer);
    @(posedge clk); #1;
    chk("pulse", rvld, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic        pw [3];
    logic [2:0]  pf [3];
    logic [31:0] pa [3];
    logic [31:0] pd [3];
    logic [31:0] ex [3];
    logic        ee [3];
    checks = 0;
    fails = 0;
    v = 0; w = 0; f = 0; a = 0; d = 0;
    sel = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready", rdy, 0);
      chk("rst_valid", rvld, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", rerr, 0);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      xact(1, 3'b010, 32'h100, 32'hDEADBEEF);
      xact(0, 3'b010, 32'h100, 0);
      xact(0, 3'b000, 32'h103, 0);
      xact(0, 3'b100, 32'h103, 0);
      xact(0, 3'b001, 32'h102, 0);
      xact(0, 3'b101, 32'h100, 0);
      xact(1, 3'b000, 32'h101, 32'h55);
      xact(1, 3'b001, 32'h102, 32'h1234);
      xact(0, 3'b010, 32'h100, 0);
      xact(0, 3'b010, 32'h102, 0);
      xact(1, 3'b001, 32'h101, 32'hFFFF);
      xact(0, 3'b010, 32'h100, 0);
      xact(0, 3'b011, 32'h100, 0);
      xact(1, 3'b100, 32'h100, 32'h77);
      xact(1, 3'b010, 32'h0002_0100, 32'hA5A5A5A5);
      xact(0, 3'b010, 32'h100, 0);
    end

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 16; i++)
        xact(1, 3'b010, 32'h300 + 32'(4 * i), $urandom);
      for (int i = 0; i < 60; i++)
        xact(1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)),
             ($urandom & 32'hFFFE_0000) |
               (32'h300 + 32'($urandom_range(0, 63))),
             $urandom);
    end

    sel = 1;
    pw[0] = 1; pf[0] = 3'b010; pa[0] = 32'h200;
    pd[0] = 32'h11223344;
    pw[1] = 0; pf[1] = 3'b010; pa[1] = 32'h200; pd[1] = 0;
    pw[2] = 0; pf[2] = 3'b001; pa[2] = 32'h202; pd[2] = 0;
    for (int k = 0; k < 3; k++)
      model(1, pw[k], pf[k], pa[k], pd[k], ex[k], ee[k]);
    w = pw[0]; f = pf[0]; a = pa[0]; d = pd[0];
    v = 1;
    for (int k = 0; k < 3; k++) begin
      chk("pl_ready", rdy, 1);
      @(posedge clk); #1;
      if (k < 2) begin
        w = pw[k+1]; f = pf[k+1];
        a = pa[k+1]; d = pd[k+1];
      end else begin
        v = 0;
      end
      chk("pl_busy1", rdy, 0);
      @(posedge clk); #1;
      chk("pl_busy2", rdy, 0);
      chk("pl_early", rvld, 0);
      @(posedge clk); #1;
      chk("pl_valid", rvld, 1);
      chk("pl_rdata", rdata, ex[k]);
      chk("pl_err", rerr, ee[k]);
    end
    @(posedge clk); #1;
    chk("pl_pulse", rvld, 0);

    w = 0; f = 3'b010; a = 32'h200; d = 0;
    v = 1;
    @(posedge clk); #1;
    v = 0;
    @(posedge clk); #1;
    chk("rs_wait", rdy, 0);
    #1 rst_n = 0;
    #1;
    chk("rs_valid", rvld, 0);
    chk("rs_rdata", rdata, 0);
    chk("rs_err", rerr, 0);
    chk("rs_ready", rdy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rs_novalid", rvld, 0);
    end
    chk("rs_rdata_post", rdata, 0);
    xact(0, 3'b010, 32'h200, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end
endmodule
